// File: rtl/servant_timer_mc_if.sv
// servant_timer_mc_if: Wishbone peripheral bus bundle between the servant core and the multi-channel timer
interface servant_timer_mc_if #(
  parameter int AW = 3
);
  logic [AW-1:0] adr;
  logic [31:0] dat;
  logic we;
  logic cyc;
  logic [31:0] rdt;
  logic ack;
  modport master (output adr, dat, we, cyc, input rdt, ack);
  modport slave (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_timer_mc.sv
// servant_timer_mc: shared-prescaler multi-channel compare timer with per-channel one-shot/periodic mode and W1C pending flags
module servant_timer_mc #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int DIVIDER = 0,
  parameter string RESET_STRATEGY = ""
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_irq,
  servant_timer_mc_if.slave wb
);
  localparam int AW = 2 + $clog2(CHANNELS);
  localparam int CW = AW - 2;
  localparam bit DP_RST = RESET_STRATEGY != "NONE";
  logic [CW-1:0] ch;
  logic [1:0] rsel;
  logic acc, wr, tick, dp_rst, ack_q, irq_q;
  logic [31:0] rdt_q, rdt_d;
  logic [CHANNELS-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
  logic [WIDTH-1:0] cmp_q [CHANNELS];
  logic [WIDTH-1:0] cmp_d [CHANNELS];
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic [WIDTH-1:0] cnt_d [CHANNELS];
  assign ch = wb.adr[AW-1:2];
  assign rsel = wb.adr[1:0];
  assign acc = wb.cyc & ~ack_q;
  assign wr = acc & wb.we;
  assign dp_rst = DP_RST & i_rst;
  if (DIVIDER == 0) begin : g_nodiv
    assign tick = 1'b1;
  end else begin : g_div
    logic [DIVIDER-1:0] pre_q;
    always_ff @(posedge i_clk) pre_q <= i_rst ? '0 : pre_q + 1'b1;
    assign tick = &pre_q;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic sel, wcnt, run, hit;
    assign sel = wr && ch == CW'(c);
    assign wcnt = sel && rsel == 2'd2;
    assign run = tick & en_q[c] & ~wcnt;
    // Match compares against the registered CMP, so a same-cycle CMP write only affects later ticks
    assign hit = run && cnt_q[c] == cmp_q[c];
    assign en_d[c] = sel && rsel == 2'd0 ? wb.dat[0] : en_q[c] & ~(hit & ~per_q[c]);
    assign per_d[c] = sel && rsel == 2'd0 ? wb.dat[1] : per_q[c];
    assign ie_d[c] = sel && rsel == 2'd0 ? wb.dat[2] : ie_q[c];
    assign cmp_d[c] = sel && rsel == 2'd1 ? wb.dat[WIDTH-1:0] : cmp_q[c];
    assign cnt_d[c] = wcnt ? wb.dat[WIDTH-1:0] : !run ? cnt_q[c] : hit ? (per_q[c] ? '0 : cnt_q[c]) : cnt_q[c] + 1'b1;
    assign pend_d[c] = hit | (pend_q[c] & ~(sel && rsel == 2'd3 && wb.dat[0]));
  end
  assign rdt_d = !acc ? rdt_q :
                 rsel == 2'd0 ? 32'({ie_q[ch], per_q[ch], en_q[ch]}) :
                 rsel == 2'd1 ? 32'(cmp_q[ch]) :
                 rsel == 2'd2 ? 32'(cnt_q[ch]) : 32'(pend_q[ch]);
  always_ff @(posedge i_clk) begin
    en_q <= i_rst ? '0 : en_d;
    per_q <= i_rst ? '0 : per_d;
    ie_q <= i_rst ? '0 : ie_d;
    pend_q <= i_rst ? '0 : pend_d;
    ack_q <= i_rst ? 1'b0 : acc;
    irq_q <= i_rst ? 1'b0 : |(pend_q & ie_q);
  end
  always_ff @(posedge i_clk) begin
    rdt_q <= dp_rst ? '0 : rdt_d;
    for (int c = 0; c < CHANNELS; c++) begin
      cmp_q[c] <= dp_rst ? '0 : cmp_d[c];
      cnt_q[c] <= dp_rst ? '0 : cnt_d[c];
    end
  end
  assign wb.ack = ack_q;
  assign wb.rdt = rdt_q;
  assign o_irq = irq_q;
endmodule

// File: tb/tb_servant_timer_mc.sv
// tb_servant_timer_mc: two timer configurations (32-bit/2ch/no prescale, 8-bit/4ch/prescale 4) against a cycle-level reference model
module tb_servant_timer_mc;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  servant_timer_mc_if #(.AW(3)) wb0 ();
  servant_timer_mc_if #(.AW(4)) wb1 ();
  logic irq0, irq1;
  logic b_cyc [2];
  logic b_we [2];
  logic [3:0] b_adr [2];
  logic [31:0] b_dat [2];
  assign wb0.cyc = b_cyc[0];
  assign wb0.we = b_we[0];
  assign wb0.adr = b_adr[0][2:0];
  assign wb0.dat = b_dat[0];
  assign wb1.cyc = b_cyc[1];
  assign wb1.we = b_we[1];
  assign wb1.adr = b_adr[1];
  assign wb1.dat = b_dat[1];
  servant_timer_mc #(.WIDTH(32), .CHANNELS(2), .DIVIDER(0)) u0 (.i_clk(clk), .i_rst(rst), .o_irq(irq0), .wb(wb0));
  servant_timer_mc #(.WIDTH(8), .CHANNELS(4), .DIVIDER(2)) u1 (.i_clk(clk), .i_rst(rst), .o_irq(irq1), .wb(wb1));
  longint m_cnt [2][8];
  longint m_cmp [2][8];
  bit m_en [2][8];
  bit m_per [2][8];
  bit m_ie [2][8];
  bit m_pend [2][8];
  int m_pre [2];
  bit m_ack [2];
  bit m_irq [2];
  longint m_rdt [2];
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  function automatic int wdt(int d); return d ? 8 : 32; endfunction
  function automatic int nch(int d); return d ? 4 : 2; endfunction
  function automatic int tick_len(int d); return d ? 4 : 1; endfunction
  function automatic longint mask_of(int d); return (64'd1 << wdt(d)) - 1; endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Reference: what one rising edge does to a timer, written from the register-level rules
  task automatic model_edge(int d);
    longint mask, v;
    int ch, r;
    bit acc, wr, tick, any, me, set;
    mask = mask_of(d);
    v = longint'(b_dat[d]);
    ch = int'(b_adr[d]) / 4;
    r = int'(b_adr[d]) % 4;
    acc = b_cyc[d] && !m_ack[d];
    wr = acc && b_we[d];
    tick = m_pre[d] == tick_len(d) - 1;
    any = 0;
    if (rst) begin
      for (int c = 0; c < 8; c++) begin
        m_cnt[d][c] = 0; m_cmp[d][c] = 0; m_en[d][c] = 0;
        m_per[d][c] = 0; m_ie[d][c] = 0; m_pend[d][c] = 0;
      end
      m_pre[d] = 0; m_ack[d] = 0; m_irq[d] = 0; m_rdt[d] = 0;
      return;
    end
    for (int c = 0; c < nch(d); c++) any |= m_pend[d][c] & m_ie[d][c];
    if (acc)
      m_rdt[d] = r == 0 ? (longint'(m_en[d][ch]) | longint'(m_per[d][ch]) << 1 | longint'(m_ie[d][ch]) << 2) :
                 r == 1 ? m_cmp[d][ch] : r == 2 ? m_cnt[d][ch] : longint'(m_pend[d][ch]);
    for (int c = 0; c < nch(d); c++) begin
      me = wr && ch == c;
      set = 0;
      if (me && r == 2) m_cnt[d][c] = v & mask;
      else if (tick && m_en[d][c]) begin
        if (m_cnt[d][c] == m_cmp[d][c]) begin
          set = 1;
          if (m_per[d][c]) m_cnt[d][c] = 0;
          else m_en[d][c] = 0;
        end else m_cnt[d][c] = (m_cnt[d][c] + 1) & mask;
      end
      if (me && r == 1) m_cmp[d][c] = v & mask;
      if (me && r == 0) begin
        m_en[d][c] = v[0]; m_per[d][c] = v[1]; m_ie[d][c] = v[2];
      end
      if (me && r == 3 && v[0]) m_pend[d][c] = 0;
      if (set) m_pend[d][c] = 1;
    end
    m_pre[d] = (m_pre[d] + 1) % tick_len(d);
    m_ack[d] = acc;
    m_irq[d] = any;
  endtask
  task automatic step();
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge clk);
    #1;
    ncyc++;
    chk("ack0", wb0.ack, m_ack[0]);
    chk("rdt0", wb0.rdt, m_rdt[0]);
    chk("irq0", irq0, m_irq[0]);
    chk("ack1", wb1.ack, m_ack[1]);
    chk("rdt1", wb1.rdt, m_rdt[1]);
    chk("irq1", irq1, m_irq[1]);
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic xfer(int d, int adr, longint dat, bit we, output logic [31:0] q);
    b_cyc[d] = 1; b_we[d] = we; b_adr[d] = 4'(adr); b_dat[d] = 32'(dat);
    step();
    chk("xfer_ack", d ? wb1.ack : wb0.ack, 1);
    q = d ? wb1.rdt : wb0.rdt;
    b_cyc[d] = 0; b_we[d] = 0;
    step();
    chk("xfer_ack_drop", d ? wb1.ack : wb0.ack, 0);
  endtask
  task automatic wr(int d, int ch, int r, longint dat);
    logic [31:0] q;
    xfer(d, ch * 4 + r, dat, 1, q);
  endtask
  task automatic rd_chk(string tag, int d, int ch, int r, longint exp);
    logic [31:0] q;
    xfer(d, ch * 4 + r, 0, 0, q);
    chk(tag, q, exp);
  endtask
  task automatic wait_irq(int d, output int t);
    int n;
    n = 0;
    while ((d ? irq1 : irq0) !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("irq_wait", d ? irq1 : irq0, 1);
    t = ncyc;
  endtask
  task automatic period_chk(string tag, int d, int ch, int exp);
    int t1, t2;
    wait_irq(d, t1);
    wr(d, ch, 3, 1);
    chk({tag, "_clr"}, d ? irq1 : irq0, 0);
    wait_irq(d, t2);
    chk(tag, t2 - t1, exp);
  endtask
  task automatic all_zero(string tag);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < nch(d); c++)
        for (int r = 0; r < 4; r++) rd_chk(tag, d, c, r, 0);
  endtask
  initial begin
    int d, c, r, hold, gap;
    longint v;
    for (int i = 0; i < 2; i++) begin
      b_cyc[i] = 0; b_we[i] = 0; b_adr[i] = 0; b_dat[i] = 0;
    end
    idle(3);
    rst = 0;
    all_zero("rst_rd");
    chk("rst_irq0", irq0, 0);
    wr(0, 0, 1, 4);
    wr(0, 0, 0, 7);
    period_chk("period_div0", 0, 0, 5);
    wr(0, 0, 0, 0);
    wr(0, 0, 3, 1);
    wr(0, 1, 1, 3);
    wr(0, 1, 0, 1);
    idle(10);
    rd_chk("oneshot_en", 0, 1, 0, 0);
    rd_chk("oneshot_cnt", 0, 1, 2, 3);
    rd_chk("oneshot_pend", 0, 1, 3, 1);
    wr(0, 1, 3, 1);
    idle(10);
    rd_chk("oneshot_nopend", 0, 1, 3, 0);
    wr(1, 0, 1, 1);
    wr(1, 0, 0, 7);
    period_chk("period_div2", 1, 0, 8);
    wr(1, 0, 0, 0);
    wr(1, 0, 3, 1);
    wr(0, 0, 1, 9);
    wr(0, 0, 0, 3);
    wr(0, 0, 2, 0);
    idle(8);
    wr(0, 0, 3, 1);
    rd_chk("w1c_vs_set", 0, 0, 3, 1);
    wr(0, 0, 1, 'h1000);
    wr(0, 0, 2, 'h55);
    rd_chk("cnt_write_tick", 0, 0, 2, 'h56);
    wr(0, 0, 0, 0);
    wr(1, 1, 1, 2);
    wr(1, 1, 2, 'hFE);
    wr(1, 1, 0, 1);
    idle(30);
    rd_chk("wrap_cnt", 1, 1, 2, 2);
    rd_chk("wrap_pend", 1, 1, 3, 1);
    rd_chk("wrap_en", 1, 1, 0, 0);
    wr(1, 2, 1, 200);
    wr(1, 2, 0, 7);
    idle(13);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_irq1", irq1, 0);
    all_zero("midrst_rd");
    for (int i = 0; i < 400; i++) begin
      d = int'($urandom_range(1, 0));
      c = int'($urandom_range(nch(d) - 1, 0));
      r = int'($urandom_range(3, 0));
      v = r == 1 ? longint'($urandom_range(12, 0)) :
          r == 2 ? ($urandom_range(1, 0) ? longint'($urandom_range(12, 0)) : mask_of(d) - longint'($urandom_range(3, 0))) :
          longint'($urandom);
      hold = int'($urandom_range(3, 1));
      gap = int'($urandom_range(3, 0));
      b_cyc[d] = 1; b_we[d] = 1'($urandom_range(1, 0)); b_adr[d] = 4'(c * 4 + r); b_dat[d] = 32'(v);
      idle(hold);
      b_cyc[d] = 0; b_we[d] = 0;
      idle(gap);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
